// File: rtl/pp_pipeline_accel_pkg.sv
// rtl/pp_pipeline_accel_pkg.sv - shared state encoding and AXI constants for the Axi2Mat AR generator
package pp_pipeline_accel_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_XFER,
        ST_CALC,
        ST_ISSUE,
        ST_DONE
    } state_t;

    localparam logic [31:0] STRIDE_CONTIG = 32'hFFFF_FFFF;
    localparam int          AXI_4K        = 4096;

endpackage

// File: rtl/pp_pipeline_accel_burst_len.sv
// rtl/pp_pipeline_accel_burst_len.sv - combinational min(rem, MAX_BURST, to4k) burst length
module pp_pipeline_accel_burst_len #(
    parameter int MAX_BURST = 16
) (
    input  logic [42:0] i_rem,
    input  logic [12:0] i_to4k,
    output logic [8:0]  o_len
);

    logic [42:0] w_cap;

    always_comb begin
        w_cap = (i_rem < 43'(MAX_BURST)) ? i_rem : 43'(MAX_BURST);
        o_len = (w_cap < 43'(i_to4k)) ? 9'(w_cap) : 9'(i_to4k);
    end

endmodule

// File: rtl/pp_pipeline_accel_axi2mat_ar_gen.sv
// rtl/pp_pipeline_accel_axi2mat_ar_gen.sv - cuts row transfers into 4KB-safe AXI4 read-address bursts
module pp_pipeline_accel_axi2mat_ar_gen
    import pp_pipeline_accel_pkg::*;
#(
    parameter int DATA_BYTES = 8,
    parameter int MAX_BURST  = 16,
    parameter int ADDR_W     = 64
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    input  logic              ap_continue,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [31:0]       stride,
    input  logic [31:0]       cols_bytes,
    input  logic [10:0]       rows_burst,
    input  logic [10:0]       rows_stride,
    output logic [ADDR_W-1:0] m_axi_gmem_ARADDR,
    output logic [7:0]        m_axi_gmem_ARLEN,
    output logic              m_axi_gmem_ARVALID,
    input  logic              m_axi_gmem_ARREADY,
    output logic [31:0]       beats_total
);

    localparam int SHIFT = $clog2(DATA_BYTES);

    state_t            r_state;
    logic [ADDR_W-1:0] r_row_addr;
    logic [ADDR_W-1:0] r_cur_addr;
    logic [31:0]       r_stride;
    logic [31:0]       r_cols;
    logic [10:0]       r_rows_burst;
    logic [10:0]       r_rows_stride;
    logic [10:0]       r_xfer_cnt;
    logic [42:0]       r_xfer_beats;
    logic [42:0]       r_rem;
    logic [8:0]        r_len;
    logic [ADDR_W-1:0] r_araddr;
    logic [7:0]        r_arlen;
    logic              r_arvalid;
    logic              r_done;
    logic [31:0]       r_beats_total;

    logic [42:0]       w_xfer_bytes;
    logic [42:0]       w_xfer_beats;
    logic [12:0]       w_to4k;
    logic [8:0]        w_len;
    logic [8:0]        w_len_m1;
    logic [42:0]       w_rem_next;
    logic [ADDR_W-1:0] w_cur_next;
    logic [32:0]       w_beats_sum;
    logic              w_zero_job;

    assign w_xfer_bytes = 43'(r_rows_burst) * 43'(r_cols);
    assign w_xfer_beats = (w_xfer_bytes + 43'(DATA_BYTES - 1)) >> SHIFT;
    assign w_to4k       = (13'(AXI_4K) - {1'b0, r_cur_addr[11:0]}) >> SHIFT;
    assign w_len_m1     = w_len - 9'd1;
    assign w_rem_next   = r_rem - 43'(r_len);
    assign w_cur_next   = r_cur_addr + (ADDR_W'(r_len) << SHIFT);
    assign w_beats_sum  = {1'b0, r_beats_total} + 33'(r_len);
    assign w_zero_job   = (r_rows_burst == 11'd0) || (r_rows_stride == 11'd0) || (r_cols == 32'd0);

    pp_pipeline_accel_burst_len #(
        .MAX_BURST (MAX_BURST)
    ) u_burst_len (
        .i_rem  (r_rem),
        .i_to4k (w_to4k),
        .o_len  (w_len)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state       <= ST_IDLE;
            r_row_addr    <= '0;
            r_cur_addr    <= '0;
            r_stride      <= '0;
            r_cols        <= '0;
            r_rows_burst  <= '0;
            r_rows_stride <= '0;
            r_xfer_cnt    <= '0;
            r_xfer_beats  <= '0;
            r_rem         <= '0;
            r_len         <= '0;
            r_araddr      <= '0;
            r_arlen       <= '0;
            r_arvalid     <= 1'b0;
            r_done        <= 1'b0;
            r_beats_total <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (ap_start) begin
                        r_row_addr    <= base_addr;
                        r_stride      <= stride;
                        r_cols        <= cols_bytes;
                        r_rows_burst  <= rows_burst;
                        r_rows_stride <= rows_stride;
                        r_state       <= ST_SETUP;
                    end
                end
                ST_SETUP: begin
                    r_beats_total <= '0;
                    r_xfer_cnt    <= '0;
                    r_xfer_beats  <= w_xfer_beats;
                    if (w_zero_job) begin
                        r_done  <= 1'b1;
                        r_state <= ST_DONE;
                    end else begin
                        r_state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    r_cur_addr <= r_row_addr;
                    r_rem      <= r_xfer_beats;
                    r_state    <= ST_CALC;
                end
                ST_CALC: begin
                    r_len     <= w_len;
                    r_araddr  <= r_cur_addr;
                    r_arlen   <= w_len_m1[7:0];
                    r_arvalid <= 1'b1;
                    r_state   <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (m_axi_gmem_ARREADY) begin
                        r_arvalid     <= 1'b0;
                        r_cur_addr    <= w_cur_next;
                        r_rem         <= w_rem_next;
                        r_beats_total <= w_beats_sum[32] ? 32'hFFFF_FFFF : w_beats_sum[31:0];
                        if (w_rem_next != 43'd0) begin
                            r_state <= ST_CALC;
                        end else begin
                            r_xfer_cnt <= r_xfer_cnt + 11'd1;
                            if (r_xfer_cnt + 11'd1 == r_rows_stride) begin
                                r_done  <= 1'b1;
                                r_state <= ST_DONE;
                            end else begin
                                // Contiguous rows simply continue where the last burst ended.
                                r_row_addr <= (r_stride == STRIDE_CONTIG) ? w_cur_next
                                                                         : r_row_addr + ADDR_W'(r_stride);
                                r_state    <= ST_XFER;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (ap_continue) begin
                        r_done  <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign ap_ready           = (r_state == ST_IDLE) && ap_start;
    assign ap_idle            = (r_state == ST_IDLE) && !ap_start;
    assign ap_done            = r_done;
    assign m_axi_gmem_ARADDR  = r_araddr;
    assign m_axi_gmem_ARLEN   = r_arlen;
    assign m_axi_gmem_ARVALID = r_arvalid;
    assign beats_total        = r_beats_total;

endmodule
